mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte address width for all address ports.
REQ-002 Parameter DATA_W, default 32, data width for all data ports; the write mask width is DATA_W/8.
REQ-003 CLK  in  1  single clock; all state changes on its rising edge.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 i_req_valid / i_req_addr  in  1 / ADDR_W  fetch-port read request.
REQ-006 i_req_ready  out  1  fetch request accepted this cycle.
REQ-007 i_rsp_valid / i_rsp_data  out  1 / DATA_W  fetch read response.
REQ-008 d_req_valid / d_req_addr / d_req_we / d_req_wdata / d_req_wmask  in  1 / ADDR_W / 1 / DATA_W / DATA_W/8  data-port load/store request.
REQ-009 d_req_ready  out  1  data request accepted this cycle.
REQ-010 d_rsp_valid / d_rsp_data  out  1 / DATA_W  data-port response (read data or store acknowledge).
REQ-011 mem_req_valid / mem_req_addr / mem_req_we / mem_req_wdata / mem_req_wmask  out  1 / ADDR_W / 1 / DATA_W / DATA_W/8  shared memory request.
REQ-012 mem_req_ready  in  1  memory accepts the request.
REQ-013 mem_rsp_valid / mem_rsp_data  in  1 / DATA_W  memory response; the memory returns exactly one response per accepted request, including writes.
REQ-014 busy  out  1  arbiter is not in IDLE.
REQ-015 err_spurious  out  1  sticky flag: mem_rsp_valid was seen outside WAIT.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE and WAIT, with only one transaction outstanding at a time.
REQ-017 In IDLE, if any req_valid is high, the arbiter SHALL grant one requester and assert only that requester's req_ready combinationally in the same cycle.
REQ-018 On grant, the arbiter SHALL latch address, we, wdata, wmask and owner, then go to ISSUE. For a fetch grant, the latched we=0 and wmask=0.
REQ-019 req_ready SHALL be 0 in ISSUE and WAIT, and in IDLE when no requester is valid.
REQ-020 In ISSUE, mem_req_valid SHALL be 1 with the latched fields held stable; when mem_req_ready=1, the FSM SHALL go to WAIT at that edge.
REQ-021 In WAIT, on mem_rsp_valid=1, the arbiter SHALL register mem_rsp_data into the owner's rsp_data and pulse the owner's rsp_valid for exactly one cycle on the following cycle, then go to IDLE at the same edge.
REQ-022 rsp_data SHALL hold its last value until the next response to that port.
REQ-023 The minimum round trip SHALL be: accept at cycle N, mem_req_valid at N+1, earliest mem_rsp_valid at N+2, rsp_valid at N+3.
REQ-024 A new request SHALL be acceptable in the cycle that rsp_valid is high, because the FSM is already in IDLE.
REQ-025 mem_rsp_valid in IDLE or ISSUE SHALL be ignored for routing and SHALL set err_spurious, which clears only on RESET.
REQ-026 mem_req_valid SHALL be 0 in IDLE and WAIT.
REQ-027 busy SHALL be 1 in ISSUE and WAIT.
REQ-028 A requester deasserting valid without a handshake SHALL cause no effect.

Reset
REQ-029 RESET asserted at any time SHALL force IDLE immediately and drive all outputs to 0: ready, rsp_valid, rsp_data, mem_req_*, busy and err_spurious.
REQ-030 An in-flight transaction at reset SHALL be abandoned, and no response for it SHALL ever be delivered.
REQ-031 After reset, the priority pointer SHALL favour the data port.

Configuration
REQ-032 Macro MEM_ARB_ROUND_ROBIN_EN defined: when both ports request in IDLE, the arbiter SHALL grant the port not granted last; a single requester SHALL always be granted.
REQ-033 Macro MEM_ARB_ROUND_ROBIN_EN undefined: the data port SHALL always win simultaneous requests (fixed priority), and no last-grant state SHALL be kept.

Verification
REQ-034 Fetch-only read: i_req addr 0x10, mem_req_ready=1, memory replies 0xDEADBEEF one cycle after accept -> mem_req_addr=0x10, mem_req_we=0 at N+1; i_rsp_valid one cycle at N+3 with i_rsp_data=0xDEADBEEF; d_rsp_valid stays 0.
REQ-035 Simultaneous requests, both held for four transactions: with the macro -> grants alternate D,I,D,I; without it -> D,D,D,D and i_req_ready never asserts.
REQ-036 Store with backpressure: d_req we=1, addr 0x20, wdata 0x12345678, wmask 0xF, mem_req_ready low for 3 cycles -> mem_req fields stable for 4 cycles of mem_req_valid; d_rsp_valid one pulse after the ack.
REQ-037 Reset mid-WAIT: assert RESET before mem_rsp_valid, release it, then the memory returns the stale response -> no rsp_valid pulse, err_spurious=1, busy=0.
REQ-038 Back-to-back: hold i_req_valid through a response -> the next i_req_ready coincides with i_rsp_valid of the previous request, and the throughput is one transaction per 3 cycles with zero-wait memory.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-outstanding shared memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating grants; otherwise the data port has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                i_req_valid,
  input  logic [ADDR_W-1:0]   i_req_addr,
  output logic                i_req_ready,
  output logic                i_rsp_valid,
  output logic [DATA_W-1:0]   i_rsp_data,
  input  logic                d_req_valid,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic                d_req_we,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_wmask,
  output logic                d_req_ready,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic                mem_req_valid,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_we,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_req_ready,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  output logic                busy,
  output logic                err_spurious
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t              state_q;
  state_t              state_nxt;
  logic                gnt_d;
  logic                gnt_i;
  logic                issue;
  logic                rsp_hit;
  logic                owner_d_p0;
  logic [ADDR_W-1:0]   addr_p0;
  logic                we_p0;
  logic [DATA_W-1:0]   wdata_p0;
  logic [MASK_W-1:0]   wmask_p0;
  logic                vld_i_p1;
  logic                vld_d_p1;
  logic [DATA_W-1:0]   data_i_p1;
  logic [DATA_W-1:0]   data_d_p1;
  logic                err_q;

  assign issue   = (state_q == ISSUE);
  assign rsp_hit = (state_q == WAIT) && mem_rsp_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_d_q resets low so the data port wins the first contested grant
  logic last_d_q;

  always_comb begin
    gnt_d = 1'b0;
    gnt_i = 1'b0;
    if (state_q == IDLE) begin
      if (d_req_valid && !(i_req_valid && last_d_q)) gnt_d = 1'b1;
      else if (i_req_valid)                          gnt_i = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)              last_d_q <= 1'b0;
    else if (gnt_d || gnt_i) last_d_q <= gnt_d;
  end
`else
  always_comb begin
    gnt_d = 1'b0;
    gnt_i = 1'b0;
    if (state_q == IDLE) begin
      if (d_req_valid)      gnt_d = 1'b1;
      else if (i_req_valid) gnt_i = 1'b1;
    end
  end
`endif

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (gnt_d || gnt_i) state_nxt = ISSUE;
      ISSUE:   if (mem_req_ready)  state_nxt = WAIT;
      WAIT:    if (mem_rsp_valid)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: request captured at grant, held through ISSUE/WAIT
  always_ff @(posedge CLK) begin
    if (gnt_d) begin
      owner_d_p0 <= 1'b1;
      addr_p0    <= d_req_addr;
      we_p0      <= d_req_we;
      wdata_p0   <= d_req_wdata;
      wmask_p0   <= d_req_wmask;
    end else if (gnt_i) begin
      owner_d_p0 <= 1'b0;
      addr_p0    <= i_req_addr;
      we_p0      <= 1'b0;
      wdata_p0   <= '0;
      wmask_p0   <= '0;
    end
  end

  // p1: response routed to its owner; data registers clear on reset so outputs read 0
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      vld_i_p1  <= 1'b0;
      vld_d_p1  <= 1'b0;
      data_i_p1 <= '0;
      data_d_p1 <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      vld_i_p1 <= rsp_hit && !owner_d_p0;
      vld_d_p1 <= rsp_hit && owner_d_p0;
      if (rsp_hit && owner_d_p0)  data_d_p1 <= mem_rsp_data;
      if (rsp_hit && !owner_d_p0) data_i_p1 <= mem_rsp_data;
      if (mem_rsp_valid && (state_q != WAIT)) err_q <= 1'b1;
    end
  end

  assign i_req_ready   = gnt_i & ~RESET;
  assign d_req_ready   = gnt_d & ~RESET;
  assign i_rsp_valid   = vld_i_p1;
  assign i_rsp_data    = data_i_p1;
  assign d_rsp_valid   = vld_d_p1;
  assign d_rsp_data    = data_d_p1;
  assign mem_req_valid = issue;
  assign mem_req_addr  = issue ? addr_p0  : '0;
  assign mem_req_we    = issue ? we_p0    : 1'b0;
  assign mem_req_wdata = issue ? wdata_p0 : '0;
  assign mem_req_wmask = issue ? wmask_p0 : '0;
  assign busy          = (state_q != IDLE);
  assign err_spurious  = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests, behavioural memory, response monitor.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        i_req_valid, i_req_ready, i_rsp_valid;
  logic [31:0] i_req_addr, i_rsp_data;
  logic        d_req_valid, d_req_we, d_req_ready, d_rsp_valid;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
  logic [3:0]  d_req_wmask;
  logic        mem_req_valid, mem_req_we, mem_req_ready, mem_rsp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
  logic [3:0]  mem_req_wmask;
  logic        busy, err_spurious;

  typedef struct {logic port_d; logic [31:0] data;} exp_t;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mem [logic [31:0]];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          stall_cfg = 0;
  int          rsp_delay = 0;
  logic [1:0]  exp_g [4];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
    .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .busy(busy), .err_spurious(err_spurious)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest expected response
  always @(negedge CLK) begin
    if (i_rsp_valid || d_rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", {i_rsp_valid, d_rsp_valid}, 2'b00);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_port", {i_rsp_valid, d_rsp_valid}, mon_e.port_d ? 2'b01 : 2'b10);
        check("rsp_data", mon_e.port_d ? d_rsp_data : i_rsp_data, mon_e.data);
      end
    end
  end

  // Behavioural memory: optional stall on each new request, reply rsp_delay cycles after accept
  logic        m_pend, m_acc_we, m_prev_vld;
  int          m_cnt, m_stall;
  logic [31:0] m_a, m_wd, m_cur;
  logic [3:0]  m_wm;
  initial begin
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    m_pend = 1'b0; m_prev_vld = 1'b0; m_cnt = 0; m_stall = 0;
    m_a = '0; m_wd = '0; m_wm = '0; m_acc_we = 1'b0; m_cur = '0;
    forever begin
      @(negedge CLK);
      if (mem_req_valid && mem_req_ready) begin
        m_pend = 1'b1; m_cnt = rsp_delay;
        m_a = mem_req_addr; m_acc_we = mem_req_we; m_wd = mem_req_wdata; m_wm = mem_req_wmask;
      end
      @(posedge CLK); #1;
      mem_rsp_valid = 1'b0;
      if (m_pend) begin
        if (m_cnt == 0) begin
          m_pend = 1'b0;
          mem_rsp_valid = 1'b1;
          m_cur = mem.exists(m_a) ? mem[m_a] : 32'h0;
          if (m_acc_we) begin
            for (int b = 0; b < 4; b++) if (m_wm[b]) m_cur[8*b +: 8] = m_wd[8*b +: 8];
            mem[m_a] = m_cur;
            mem_rsp_data = 32'h0;
          end else begin
            mem_rsp_data = m_cur;
          end
        end else begin
          m_cnt--;
        end
      end
      if (mem_req_valid && !m_prev_vld) m_stall = stall_cfg;
      m_prev_vld = mem_req_valid;
      if (mem_req_valid && m_stall > 0) begin
        mem_req_ready = 1'b0;
        m_stall--;
      end else begin
        mem_req_ready = 1'b1;
      end
    end
  end

  task automatic do_req(input logic port_d, input logic [31:0] addr, input logic we,
                        input logic [31:0] wdata, input logic [3:0] wmask, input logic [31:0] expd);
    logic seen;
    seen = 1'b0;
    @(posedge CLK); #1;
    if (port_d) begin
      d_req_valid = 1'b1; d_req_addr = addr; d_req_we = we; d_req_wdata = wdata; d_req_wmask = wmask;
    end else begin
      i_req_valid = 1'b1; i_req_addr = addr;
    end
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (port_d ? d_req_ready : i_req_ready) begin
        seen = 1'b1;
        sb.push_back('{port_d, expd});
        break;
      end
    end
    check("req_accepted", seen, 1'b1);
    @(posedge CLK); #1;
    d_req_valid = 1'b0;
    i_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (!busy && sb.size() == 0) break;
    end
    check("drain_busy", busy, 1'b0);
    check("drain_sb", sb.size(), 0);
  endtask

  int n_grant, n_acc, last_cyc, vcnt;
  initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
`else
    exp_g[0] = 2'b10; exp_g[1] = 2'b10; exp_g[2] = 2'b10; exp_g[3] = 2'b10;
`endif
    mem[32'h10] = 32'hDEADBEEF;
    mem[32'h24] = 32'h11223344;
    mem[32'h40] = 32'hA5A50040;
    mem[32'h44] = 32'h5A5A0044;
    mem[32'h30] = 32'hCAFEF00D;
    i_req_valid = 1'b0; i_req_addr = '0;
    d_req_valid = 1'b1; d_req_addr = '0; d_req_we = 1'b0; d_req_wdata = '0; d_req_wmask = '0;
    RESET = 1'b1;

    // Reset state, with a data request pending to show ready is held low
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_d_ready", d_req_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_spurious, 1'b0);
    check("rst_mem_valid", mem_req_valid, 1'b0);
    check("rst_rsp_valid", {i_rsp_valid, d_rsp_valid}, 2'b00);
    check("rst_rsp_data", {i_rsp_data, d_rsp_data}, 64'h0);
    d_req_valid = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;

    // Fetch read with minimum latency
    @(posedge CLK); #1;
    i_req_valid = 1'b1; i_req_addr = 32'h10;
    @(negedge CLK);
    check("f_i_ready", i_req_ready, 1'b1);
    check("f_d_ready", d_req_ready, 1'b0);
    sb.push_back('{1'b0, 32'hDEADBEEF});
    @(posedge CLK); #1;
    i_req_valid = 1'b0;
    @(negedge CLK);
    check("f_mem_valid", mem_req_valid, 1'b1);
    check("f_mem_addr", mem_req_addr, 32'h10);
    check("f_mem_we", mem_req_we, 1'b0);
    check("f_mem_wmask", mem_req_wmask, 4'h0);
    check("f_busy", busy, 1'b1);
    check("f_i_ready_busy", i_req_ready, 1'b0);
    @(negedge CLK);
    check("f_rsp_early", i_rsp_valid, 1'b0);
    @(negedge CLK);
    check("f_rsp_n3", i_rsp_valid, 1'b1);
    check("f_d_rsp_quiet", d_rsp_valid, 1'b0);
    check("f_busy_done", busy, 1'b0);
    wait_idle();

    // Simultaneous requests held for four grants
    @(posedge CLK); #1;
    d_req_valid = 1'b1; d_req_addr = 32'h40; d_req_we = 1'b0; d_req_wmask = 4'h0;
    i_req_valid = 1'b1; i_req_addr = 32'h44;
    n_grant = 0;
    for (int k = 0; k < 60 && n_grant < 4; k++) begin
      @(negedge CLK);
      if (d_req_ready || i_req_ready) begin
        check("sim_grant", {d_req_ready, i_req_ready}, exp_g[n_grant]);
        if (exp_g[n_grant][1]) sb.push_back('{1'b1, 32'hA5A50040});
        else                   sb.push_back('{1'b0, 32'h5A5A0044});
        n_grant++;
      end
    end
    check("sim_grant_count", n_grant, 4);
    @(posedge CLK); #1;
    d_req_valid = 1'b0; i_req_valid = 1'b0;
    wait_idle();

    // Store with 3 cycles of backpressure; a fetch pulse meanwhile must be ignored
    stall_cfg = 3;
    @(posedge CLK); #1;
    d_req_valid = 1'b1; d_req_addr = 32'h20; d_req_we = 1'b1;
    d_req_wdata = 32'h12345678; d_req_wmask = 4'hF;
    @(negedge CLK);
    check("st_d_ready", d_req_ready, 1'b1);
    sb.push_back('{1'b1, 32'h0});
    @(posedge CLK); #1;
    d_req_valid = 1'b0; d_req_we = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 32'h50;
    vcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (k == 0) check("st_i_ready_issue", i_req_ready, 1'b0);
      if (!mem_req_valid) break;
      vcnt++;
      check("st_addr", mem_req_addr, 32'h20);
      check("st_we", mem_req_we, 1'b1);
      check("st_wdata", mem_req_wdata, 32'h12345678);
      check("st_wmask", mem_req_wmask, 4'hF);
      if (k == 0) begin
        @(posedge CLK); #1;
        i_req_valid = 1'b0;
      end
    end
    check("st_valid_cycles", vcnt, 4);
    stall_cfg = 0;
    wait_idle();
    do_req(1'b0, 32'h20, 1'b0, 32'h0, 4'h0, 32'h12345678);
    wait_idle();

    // Partial byte mask store, then read back through the data port
    do_req(1'b1, 32'h24, 1'b1, 32'hAABBCCDD, 4'h5, 32'h0);
    wait_idle();
    do_req(1'b1, 32'h24, 1'b0, 32'h0, 4'h0, 32'h11BB33DD);
    wait_idle();

    // Back-to-back fetches: accept coincides with previous response, 3-cycle spacing
    @(posedge CLK); #1;
    i_req_valid = 1'b1; i_req_addr = 32'h10;
    n_acc = 0; last_cyc = 0;
    for (int k = 0; k < 40 && n_acc < 3; k++) begin
      @(negedge CLK);
      if (i_req_ready) begin
        check("b2b_rsp_coincide", i_rsp_valid, (n_acc > 0));
        if (n_acc > 0) check("b2b_spacing", cyc - last_cyc, 3);
        last_cyc = cyc;
        sb.push_back('{1'b0, 32'hDEADBEEF});
        n_acc++;
      end
    end
    check("b2b_count", n_acc, 3);
    @(posedge CLK); #1;
    i_req_valid = 1'b0;
    wait_idle();

    // Reset during WAIT; the late response must be flagged, not delivered
    rsp_delay = 3;
    @(posedge CLK); #1;
    d_req_valid = 1'b1; d_req_addr = 32'h30; d_req_we = 1'b0;
    @(negedge CLK);
    check("rw_d_ready", d_req_ready, 1'b1);
    @(posedge CLK); #1;
    d_req_valid = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("rw_busy_wait", busy, 1'b1);
    check("rw_mem_valid_wait", mem_req_valid, 1'b0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(negedge CLK);
    check("rw_busy_rst", busy, 1'b0);
    check("rw_err_rst", err_spurious, 1'b0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    repeat (4) @(negedge CLK);
    check("rw_err_set", err_spurious, 1'b1);
    check("rw_busy_after", busy, 1'b0);
    rsp_delay = 0;
    repeat (3) @(negedge CLK);
    check("rw_err_sticky", err_spurious, 1'b1);

    for (int k = 0; k < 50; k++) begin
      if (sb.size() == 0) break;
      @(negedge CLK);
    end
    check("final_sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
